// File: rtl/gamepad_pkg.sv
// Shared types and ASCII constants for the gamepad status-line transmitter.
// Latency: n/a. Backpressure: n/a.
package gamepad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    B1,
    B2,
    NL
  } state_t;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_NL = 8'h0A;
  localparam int         MSG_LEN = 4;

  function automatic logic [7:0] led_char(input logic b);
    return b ? CH_1 : CH_0;
  endfunction

endpackage

// File: rtl/gamepad_refresh_timer.sv
// Counts idle cycles and flags when a periodic refresh line is due.
// Latency: due_o is combinational from the counter. Backpressure: counts only while run_i is high.
module gamepad_refresh_timer #(
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic clr_i,
  output logic due_o
);

  localparam int CW     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TERM_I = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TERM = CW'(TERM_I);

  logic [CW-1:0] cnt_q;

  // A due count is consumed by the line start (clr_i), so it never needs to wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (REFRESH_CYCLES == 0 || clr_i) begin
      cnt_q <= '0;
    end else if (run_i && !due_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign due_o = (REFRESH_CYCLES != 0) && (cnt_q == TERM);

endmodule

// File: rtl/gamepad_led_tx.sv
// Emits "L<led1><led2>\n" status lines on a byte stream on LED change, after reset/enable, and on refresh.
// Latency: line starts 1 cycle after led_q differs; 4 bytes per line. Backpressure: each byte held until tx_ready_i.
module gamepad_led_tx
  import gamepad_pkg::*;
#(
  parameter int REFRESH_CYCLES = 1_000_000,
  parameter int CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             led1_i,
  input  logic             led2_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] msg_cnt_o
);

  state_t     state_q, state_d;
  logic [1:0] led_q, sent_q;
  logic       sent_vld_q;
  logic [7:0] data_d;
  logic       valid_d;
  logic       start;
  logic       line_done;
  logic       refresh_due;
  logic       accept;

  assign accept = tx_valid_o && tx_ready_i;
  assign busy_o = (state_q != IDLE);

  gamepad_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .run_i ((state_q == IDLE) && en_i),
    .clr_i (start),
    .due_o (refresh_due)
  );

  // Payload bytes are drawn from sent_q, the snapshot taken at line start.
  always_comb begin
    state_d   = state_q;
    valid_d   = tx_valid_o;
    data_d    = tx_data_o;
    start     = 1'b0;
    line_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en_i && (!sent_vld_q || (led_q != sent_q) || refresh_due)) begin
          start   = 1'b1;
          state_d = HDR;
          valid_d = 1'b1;
          data_d  = CH_L;
        end
      end
      HDR: begin
        if (accept) begin
          state_d = B1;
          data_d  = led_char(sent_q[1]);
        end
      end
      B1: begin
        if (accept) begin
          state_d = B2;
          data_d  = led_char(sent_q[0]);
        end
      end
      B2: begin
        if (accept) begin
          state_d = NL;
          data_d  = CH_NL;
        end
      end
      NL: begin
        if (accept) begin
          state_d   = IDLE;
          valid_d   = 1'b0;
          data_d    = 8'h00;
          line_done = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      state_q    <= state_d;
      tx_valid_o <= valid_d;
      tx_data_o  <= data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_q      <= 2'b00;
      sent_q     <= 2'b00;
      sent_vld_q <= 1'b0;
      msg_cnt_o  <= '0;
    end else begin
      led_q <= {led1_i, led2_i};
      if (start) begin
        sent_q     <= led_q;
        sent_vld_q <= 1'b1;
      end
      if (line_done) begin
        msg_cnt_o <= msg_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gamepad_led_tx.sv
// Directed bench: instance a (no refresh, 2-bit counter) for line/backpressure/enable/reset/wrap,
// instance b (refresh every 8 idle cycles) for the periodic refresh.
module tb_gamepad_led_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, l1_a, l2_a, rdy_a;
  logic [7:0] data_a;
  logic       vld_a, busy_a;
  logic [1:0] cnt_a;
  logic       en_b, l1_b, l2_b, rdy_b;
  logic [7:0] data_b;
  logic       vld_b, busy_b;
  logic [15:0] cnt_b;

  int checks = 0;
  int failures = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  gamepad_led_tx #(.REFRESH_CYCLES(0), .CNT_W(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .led1_i(l1_a), .led2_i(l2_a),
    .tx_data_o(data_a), .tx_valid_o(vld_a), .tx_ready_i(rdy_a),
    .busy_o(busy_a), .msg_cnt_o(cnt_a)
  );

  gamepad_led_tx #(.REFRESH_CYCLES(8), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .led1_i(l1_b), .led2_i(l2_b),
    .tx_data_o(data_b), .tx_valid_o(vld_b), .tx_ready_i(rdy_b),
    .busy_o(busy_b), .msg_cnt_o(cnt_b)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Records bytes handshaken on instance a: a byte is taken at the next posedge iff valid&&ready now.
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      if (vld_a && rdy_a) got.push_back(data_a);
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en_a = 1'b0; l1_a = 1'b1; l2_a = 1'b0; rdy_a = 1'b1;
    en_b = 1'b0; l1_b = 1'b0; l2_b = 1'b0; rdy_b = 1'b1;
    repeat (3) tick();
    checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b want=0", vld_a); end
    checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b want=0", busy_a); end
    checks++; if (cnt_a !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", cnt_a); end
  endtask

  task automatic test_initial_line();
    rst_n = 1'b1;
    tick();
    tick();
    en_a = 1'b1;
    tick();
    exp_q = '{8'h4C, 8'h31, 8'h30, 8'h0A};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vld_a !== 1'b1 || data_a !== exp_q[i]) begin
        failures++;
        $display("FAIL initial_byte%0d got vld=%0b data=%h want vld=1 data=%h", i, vld_a, data_a, exp_q[i]);
      end
      tick();
    end
    checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL initial_end_valid got=%0b want=0", vld_a); end
    checks++; if (cnt_a !== 2'd1) begin failures++; $display("FAIL initial_cnt got=%0d want=1", cnt_a); end
    got = {};
    collect(30);
    checks++; if (got.size() != 0) begin failures++; $display("FAIL no_refresh got=%0d bytes want=0", got.size()); end
  endtask

  task automatic test_backpressure();
    rdy_a = 1'b0;
    l1_a = 1'b0; l2_a = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (vld_a !== 1'b1 || data_a !== 8'h4C) begin
        failures++;
        $display("FAIL bp_hold%0d got vld=%0b data=%h want vld=1 data=4c", i, vld_a, data_a);
      end
      if (i < 2) tick();
    end
    rdy_a = 1'b1;
    got = {};
    collect(10);
    exp_q = '{8'h4C, 8'h30, 8'h31, 8'h0A};
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL bp_len got=%0d want=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d got=%h want=%h", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (cnt_a !== 2'd2) begin failures++; $display("FAIL bp_cnt got=%0d want=2", cnt_a); end
  endtask

  task automatic test_coalesce();
    l1_a = 1'b0; l2_a = 1'b0;
    tick();
    tick();
    got = {};
    got.push_back(vld_a ? data_a : 8'hFF);
    tick();
    got.push_back(vld_a ? data_a : 8'hFF);
    l1_a = 1'b1; l2_a = 1'b1;
    tick();
    got.push_back(vld_a ? data_a : 8'hFF);
    l1_a = 1'b0; l2_a = 1'b1;
    tick();
    collect(12);
    exp_q = '{8'h4C, 8'h30, 8'h30, 8'h0A, 8'h4C, 8'h30, 8'h31, 8'h0A};
    checks++;
    if (got.size() != 8) begin
      failures++; $display("FAIL coalesce_len got=%0d want=8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin failures++; $display("FAIL coalesce_byte%0d got=%h want=%h", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (cnt_a !== 2'd0) begin failures++; $display("FAIL coalesce_cnt got=%0d want=0", cnt_a); end
  endtask

  task automatic test_enable();
    l1_a = 1'b1; l2_a = 1'b0;
    tick();
    tick();
    got = {};
    got.push_back(vld_a ? data_a : 8'hFF);
    tick();
    got.push_back(vld_a ? data_a : 8'hFF);
    tick();
    got.push_back(vld_a ? data_a : 8'hFF);
    en_a = 1'b0;
    tick();
    collect(4);
    l1_a = 1'b1; l2_a = 1'b1;
    collect(10);
    exp_q = '{8'h4C, 8'h31, 8'h30, 8'h0A};
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL en_low_len got=%0d want=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin failures++; $display("FAIL en_low_byte%0d got=%h want=%h", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL en_low_busy got=%0b want=0", busy_a); end
    en_a = 1'b1;
    got = {};
    collect(10);
    exp_q = '{8'h4C, 8'h31, 8'h31, 8'h0A};
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL en_rise_len got=%0d want=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin failures++; $display("FAIL en_rise_byte%0d got=%h want=%h", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (cnt_a !== 2'd2) begin failures++; $display("FAIL en_cnt got=%0d want=2", cnt_a); end
  endtask

  task automatic test_reset_mid();
    l1_a = 1'b0; l2_a = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_inflight got busy=%0b want=1", busy_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b want=0", vld_a); end
    checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h want=00", data_a); end
    checks++; if (cnt_a !== 2'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d want=0", cnt_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b want=0", busy_a); end
    tick();
    rst_n = 1'b1;
    got = {};
    collect(10);
    exp_q = '{8'h4C, 8'h30, 8'h30, 8'h0A};
    checks++;
    if (got.size() != 4) begin
      failures++; $display("FAIL post_rst_len got=%0d want=4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== exp_q[i]) begin failures++; $display("FAIL post_rst_byte%0d got=%h want=%h", i, got[i], exp_q[i]); end
      end
    end
    checks++; if (cnt_a !== 2'd1) begin failures++; $display("FAIL post_rst_cnt got=%0d want=1", cnt_a); end
  endtask

  task automatic test_wrap();
    logic [1:0] want [3];
    want = '{2'd2, 2'd3, 2'd0};
    for (int k = 0; k < 3; k++) begin
      l1_a = ~l1_a;
      got = {};
      collect(8);
      checks++;
      if (cnt_a !== want[k] || got.size() != 4) begin
        failures++;
        $display("FAIL wrap_line%0d got cnt=%0d bytes=%0d want cnt=%0d bytes=4", k, cnt_a, got.size(), want[k]);
      end
    end
  endtask

  task automatic test_refresh();
    int starts[$];
    logic prev;
    prev = vld_b;
    en_b = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (vld_b && !prev) begin
        starts.push_back(i);
        checks++;
        if (data_b !== 8'h4C) begin failures++; $display("FAIL refresh_hdr%0d got=%h want=4c", i, data_b); end
      end
      prev = vld_b;
    end
    checks++;
    if (starts.size() != 4) begin
      failures++; $display("FAIL refresh_count got=%0d want=4", starts.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (starts[k] != 12 * k) begin failures++; $display("FAIL refresh_start%0d got=%0d want=%0d", k, starts[k], 12 * k); end
      end
    end
    checks++; if (cnt_b !== 16'd3) begin failures++; $display("FAIL refresh_cnt got=%0d want=3", cnt_b); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_initial_line();
    test_backpressure();
    test_coalesce();
    test_enable();
    test_reset_mid();
    test_wrap();
    test_refresh();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
